// File: rtl/local_history_predictor.sv
// rtl/local_history_predictor.sv - two-level local branch predictor with init sweep,
// forwarded one-deep update stage and saturating mispredict counter
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module local_history_predictor #(
  parameter int ADDR_WIDTH    = `ADDR_WIDTH,
  parameter int PC_LSB        = 2,
  parameter int HIST_IDX_BITS = 10,
  parameter int HIST_LEN      = 10,
  parameter int CTR_BITS      = 2,
  parameter int CNT_BITS      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  input  logic [ADDR_WIDTH-1:0] i_req_target,
  output logic                  o_req_prediction,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic                  i_fb_prediction,
  input  logic                  i_fb_outcome,
  output logic                  o_ready,
  output logic [CNT_BITS-1:0]   o_mispredict_count
);

  localparam int HIST_ENTRIES = 1 << HIST_IDX_BITS;
  localparam int PAT_ENTRIES  = 1 << HIST_LEN;
  localparam int PTR_W        = (HIST_IDX_BITS > HIST_LEN) ? HIST_IDX_BITS : HIST_LEN;
  // N = max(2^HIST_IDX_BITS, 2^HIST_LEN) = 2^PTR_W, so the last sweep index is all ones
  localparam logic [PTR_W-1:0] PTR_LAST   = '1;
  localparam logic [PTR_W:0]   HIST_LIMIT = (PTR_W+1)'(HIST_ENTRIES);
  localparam logic [PTR_W:0]   PAT_LIMIT  = (PTR_W+1)'(PAT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_WT  = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      upd_valid_q, upd_valid_d;
  logic [HIST_IDX_BITS-1:0]  upd_hidx_q, upd_hidx_d;
  logic [HIST_LEN-1:0]       upd_pidx_q, upd_pidx_d;
  logic [HIST_LEN-1:0]       upd_hist_q, upd_hist_d;
  logic [CTR_BITS-1:0]       upd_ctr_q, upd_ctr_d;
  logic [CNT_BITS-1:0]       cnt_q, cnt_d;

  logic [HIST_LEN-1:0]       hist_mem [HIST_ENTRIES];
  logic [CTR_BITS-1:0]       ctr_mem  [PAT_ENTRIES];

  logic                      hist_we, ctr_we;
  logic [HIST_IDX_BITS-1:0]  hist_waddr;
  logic [HIST_LEN-1:0]       hist_wdata;
  logic [HIST_LEN-1:0]       ctr_waddr;
  logic [CTR_BITS-1:0]       ctr_wdata;

  logic [HIST_IDX_BITS-1:0]  fb_hidx, req_hidx;
  logic [HIST_LEN-1:0]       fb_hist, req_hist, fb_hist_new;
  logic [HIST_LEN:0]         fb_shift;
  logic [CTR_BITS-1:0]       fb_ctr, req_ctr, fb_ctr_new;
  logic                      run;
  logic                      unused_inputs;

  assign run           = (state_q == S_RUN);
  assign unused_inputs = ^{i_req_valid, i_req_target, i_req_pc, i_fb_pc};

  // Both read paths see the pending update-stage write before the tables do
  assign fb_hidx  = i_fb_pc[PC_LSB +: HIST_IDX_BITS];
  assign fb_hist  = (upd_valid_q && upd_hidx_q == fb_hidx) ? upd_hist_q : hist_mem[fb_hidx];
  assign fb_ctr   = (upd_valid_q && upd_pidx_q == fb_hist) ? upd_ctr_q : ctr_mem[fb_hist];
  assign req_hidx = i_req_pc[PC_LSB +: HIST_IDX_BITS];
  assign req_hist = (upd_valid_q && upd_hidx_q == req_hidx) ? upd_hist_q : hist_mem[req_hidx];
  assign req_ctr  = (upd_valid_q && upd_pidx_q == req_hist) ? upd_ctr_q : ctr_mem[req_hist];

  assign fb_shift    = {i_fb_outcome, fb_hist};
  assign fb_hist_new = fb_shift[HIST_LEN:1];

  always_comb begin
    fb_ctr_new = fb_ctr;
    if (i_fb_outcome) begin
      if (fb_ctr != CTR_MAX) fb_ctr_new = fb_ctr + CTR_BITS'(1);
    end else begin
      if (fb_ctr != '0) fb_ctr_new = fb_ctr - CTR_BITS'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    upd_valid_d = 1'b0;
    upd_hidx_d  = upd_hidx_q;
    upd_pidx_d  = upd_pidx_q;
    upd_hist_d  = upd_hist_q;
    upd_ctr_d   = upd_ctr_q;
    cnt_d       = cnt_q;
    if (state_q == S_INIT) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (ptr_q == PTR_LAST) state_d = S_RUN;
    end else if (i_fb_valid) begin
      upd_valid_d = 1'b1;
      upd_hidx_d  = fb_hidx;
      upd_pidx_d  = fb_hist;
      upd_hist_d  = fb_hist_new;
      upd_ctr_d   = fb_ctr_new;
      if ((i_fb_prediction != i_fb_outcome) && (cnt_q != '1)) cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_comb begin
    hist_we    = 1'b0;
    hist_waddr = upd_hidx_q;
    hist_wdata = upd_hist_q;
    ctr_we     = 1'b0;
    ctr_waddr  = upd_pidx_q;
    ctr_wdata  = upd_ctr_q;
    if (state_q == S_INIT) begin
      hist_we    = ({1'b0, ptr_q} < HIST_LIMIT);
      hist_waddr = ptr_q[HIST_IDX_BITS-1:0];
      hist_wdata = '0;
      ctr_we     = ({1'b0, ptr_q} < PAT_LIMIT);
      ctr_waddr  = ptr_q[HIST_LEN-1:0];
      ctr_wdata  = CTR_WT;
    end else begin
      hist_we = upd_valid_q;
      ctr_we  = upd_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_hidx_q  <= '0;
      upd_pidx_q  <= '0;
      upd_hist_q  <= '0;
      upd_ctr_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      upd_valid_q <= upd_valid_d;
      upd_hidx_q  <= upd_hidx_d;
      upd_pidx_q  <= upd_pidx_d;
      upd_hist_q  <= upd_hist_d;
      upd_ctr_q   <= upd_ctr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Tables are cleared by the INIT sweep rather than by reset
  always_ff @(posedge clk) begin
    if (hist_we) hist_mem[hist_waddr] <= hist_wdata;
    if (ctr_we)  ctr_mem[ctr_waddr]   <= ctr_wdata;
  end

  assign o_req_prediction   = run && req_ctr[CTR_BITS-1];
  assign o_ready            = run;
  assign o_mispredict_count = cnt_q;

endmodule

// File: tb/tb_local_history_predictor.sv
// tb/tb_local_history_predictor.sv - randomized bench checked against a table-level model
module tb_local_history_predictor;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [AW-1:0] req_pc, req_target;
  logic          fb_valid;
  logic [AW-1:0] fb_pc;
  logic          fb_pred, fb_out;
  logic          pred, ready;
  logic [31:0]   mcount;
  logic          pred2, ready2;
  logic [1:0]    mcount2;

  int total = 0;
  int bad   = 0;

  int m_hist [1024];
  int m_ctr  [1024];
  int m_cnt;

  always #5 clk = ~clk;

  local_history_predictor #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_pc(req_pc), .i_req_target(req_target),
    .o_req_prediction(pred),
    .i_fb_valid(fb_valid), .i_fb_pc(fb_pc), .i_fb_prediction(fb_pred), .i_fb_outcome(fb_out),
    .o_ready(ready), .o_mispredict_count(mcount)
  );

  local_history_predictor #(.ADDR_WIDTH(AW), .HIST_IDX_BITS(4), .HIST_LEN(3), .CTR_BITS(2), .CNT_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_pc(req_pc), .i_req_target(req_target),
    .o_req_prediction(pred2),
    .i_fb_valid(fb_valid), .i_fb_pc(fb_pc), .i_fb_prediction(fb_pred), .i_fb_outcome(fb_out),
    .o_ready(ready2), .o_mispredict_count(mcount2)
  );

  function automatic void model_reset();
    for (int i = 0; i < 1024; i++) begin
      m_hist[i] = 0;
      m_ctr[i]  = 2;
    end
    m_cnt = 0;
  endfunction

  function automatic logic model_pred(input logic [AW-1:0] pc);
    int h;
    h = int'((pc >> 2) % 1024);
    return logic'(m_ctr[m_hist[h]] >= 2);
  endfunction

  function automatic void model_fb(input logic [AW-1:0] pc, input logic p, input logic o);
    int h;
    int pat;
    h   = int'((pc >> 2) % 1024);
    pat = m_hist[h];
    if (o) m_ctr[pat] = (m_ctr[pat] == 3) ? 3 : m_ctr[pat] + 1;
    else   m_ctr[pat] = (m_ctr[pat] == 0) ? 0 : m_ctr[pat] - 1;
    m_hist[h] = (m_hist[h] / 2) + (o ? 512 : 0);
    if (p != o) m_cnt++;
  endfunction

  task automatic set_in(input logic [AW-1:0] rpc, input logic fv, input logic [AW-1:0] fpc,
                        input logic fp, input logic fo);
    req_valid  = 1'b1;
    req_pc     = rpc;
    req_target = $urandom;
    fb_valid   = fv;
    fb_pc      = fpc;
    fb_pred    = fp;
    fb_out     = fo;
    #1;
  endtask

  task automatic end_cycle(input bit apply);
    if (apply && fb_valid) model_fb(fb_pc, fb_pred, fb_out);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic run_init(input bit noisy, output int n1);
    n1 = 0;
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom, noisy, $urandom, 1'b0, noisy);
      if (ready) break;
      n1++;
      end_cycle(0);
    end
    fb_valid = 1'b0;
  endtask

  function automatic logic [AW-1:0] small_pc();
    return AW'(($urandom_range(0, 3) << 2) | ($urandom_range(0, 1) << 12) | $urandom_range(0, 3));
  endfunction

  task automatic test_reset();
    int n1 = 0;
    int n2 = 0;
    set_in(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    total++;
    if (ready !== 1'b0 || pred !== 1'b0 || mcount !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b pred=%b count=%0d, want 0 0 0", ready, pred, mcount);
    end
    total++;
    if (ready2 !== 1'b0 || pred2 !== 1'b0 || mcount2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs_small: ready=%b pred=%b count=%0d, want 0 0 0", ready2, pred2, mcount2);
    end
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom, 1'b0, 32'h0, 1'b0, 1'b0);
      if (ready) break;
      n1++;
      if (!ready2) n2++;
      total++;
      if (pred !== 1'b0) begin
        bad++;
        $display("FAIL init_pred: cycle %0d got %b want 0", n1, pred);
      end
      end_cycle(0);
    end
    total++;
    if (n1 != 1024) begin
      bad++;
      $display("FAIL init_len: o_ready low for %0d cycles, want 1024", n1);
    end
    total++;
    if (n2 != 16) begin
      bad++;
      $display("FAIL init_len_small: o_ready low for %0d cycles, want 16", n2);
    end
    for (int i = 0; i < 6; i++) begin
      set_in($urandom, 1'b0, 32'h0, 1'b0, 1'b0);
      total++;
      if (pred !== 1'b1) begin
        bad++;
        $display("FAIL ready_pred_wt: pc=%h got %b want 1", req_pc, pred);
      end
      end_cycle(0);
    end
  endtask

  task automatic test_mid_init_reset();
    int n1;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      set_in($urandom, 1'b1, $urandom, 1'b0, 1'b1);
      total++;
      if (mcount !== 32'd0 || ready !== 1'b0) begin
        bad++;
        $display("FAIL init_fb_ignored: count=%0d ready=%b want 0 0", mcount, ready);
      end
      end_cycle(0);
    end
    do_reset();
    run_init(1'b1, n1);
    total++;
    if (n1 != 1024) begin
      bad++;
      $display("FAIL reinit_len: o_ready low for %0d cycles, want 1024", n1);
    end
    total++;
    if (mcount !== 32'd0) begin
      bad++;
      $display("FAIL reinit_count: got %0d want 0", mcount);
    end
    end_cycle(0);
  endtask

  task automatic test_back_to_back();
    int pats [4] = '{0, 'h200, 'h300, 'h380};
    for (int k = 0; k < 4; k++) begin
      set_in(32'h40, 1'b1, 32'h40, 1'($urandom), 1'b1);
      total++;
      if (pred !== model_pred(32'h40)) begin
        bad++;
        $display("FAIL b2b_pred: step %0d got %b want %b", k, pred, model_pred(32'h40));
      end
      end_cycle(1);
    end
    set_in(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (pred !== 1'b1) begin
      bad++;
      $display("FAIL b2b_pred_3c0: got %b want 1", pred);
    end
    end_cycle(0);
    set_in(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (dut.hist_mem[16] !== 10'b1111000000) begin
      bad++;
      $display("FAIL b2b_hist: got %b want 1111000000", dut.hist_mem[16]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut.ctr_mem[pats[i]] !== 2'b11) begin
        bad++;
        $display("FAIL b2b_ctr: pattern %h got %b want 11", pats[i], dut.ctr_mem[pats[i]]);
      end
    end
    total++;
    if (mcount !== 32'(m_cnt)) begin
      bad++;
      $display("FAIL b2b_count: got %0d want %0d", mcount, m_cnt);
    end
    end_cycle(0);
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++) begin
      set_in(32'h100, 1'b1, 32'h100, 1'($urandom), 1'b0);
      total++;
      if (pred !== model_pred(32'h100)) begin
        bad++;
        $display("FAIL sat_pred: step %0d got %b want %b", k, pred, model_pred(32'h100));
      end
      end_cycle(1);
    end
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (pred !== 1'b0) begin
      bad++;
      $display("FAIL sat_pred_nt: got %b want 0", pred);
    end
    end_cycle(0);
    set_in(32'h100, 1'b1, 32'h100, 1'b1, 1'b0);
    total++;
    if (dut.ctr_mem[0] !== 2'b00) begin
      bad++;
      $display("FAIL sat_ctr5: got %b want 00", dut.ctr_mem[0]);
    end
    end_cycle(1);
    set_in(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (pred !== 1'b0) begin
      bad++;
      $display("FAIL sat_pred6: got %b want 0", pred);
    end
    end_cycle(0);
    set_in(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (dut.ctr_mem[0] !== 2'b00) begin
      bad++;
      $display("FAIL sat_ctr6: got %b want 00", dut.ctr_mem[0]);
    end
    end_cycle(0);
  endtask

  task automatic test_alternating();
    int   k = 0;
    bit   fv;
    logic nxt;
    for (int c = 0; c < 400 && k < 40; c++) begin
      fv  = ($urandom_range(0, 3) != 0);
      nxt = logic'(k % 2 == 0);
      set_in(32'h80, fv, 32'h80, 1'($urandom), nxt);
      total++;
      if (pred !== model_pred(32'h80)) begin
        bad++;
        $display("FAIL alt_model: fb %0d got %b want %b", k, pred, model_pred(32'h80));
      end
      if (k >= 14) begin
        total++;
        if (pred !== nxt) begin
          bad++;
          $display("FAIL alt_next: fb %0d got %b want %b", k, pred, nxt);
        end
      end
      end_cycle(1);
      if (fv) k++;
    end
  endtask

  task automatic test_mispredict();
    int   n1;
    logic o;
    do_reset();
    run_init(1'b0, n1);
    end_cycle(0);
    for (int i = 0; i < 12; i++) begin
      o = 1'($urandom);
      set_in($urandom, 1'b1, $urandom, o ^ (i == 1 || i == 4 || i == 8 || i >= 10), o);
      if (i == 10) begin
        total++;
        if (mcount !== 32'd3 || mcount2 !== 2'd3) begin
          bad++;
          $display("FAIL mis_count3: got %0d/%0d want 3/3", mcount, mcount2);
        end
      end
      end_cycle(1);
    end
    set_in(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (mcount !== 32'd5 || mcount !== 32'(m_cnt)) begin
      bad++;
      $display("FAIL mis_count5: got %0d want 5 (model %0d)", mcount, m_cnt);
    end
    total++;
    if (mcount2 !== 2'd3) begin
      bad++;
      $display("FAIL mis_count_sat: got %0d want 3", mcount2);
    end
    end_cycle(0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_in(small_pc(), 1'($urandom), small_pc(), 1'($urandom), 1'($urandom));
      total++;
      if (pred !== model_pred(req_pc)) begin
        bad++;
        $display("FAIL rand_pred: cycle %0d pc=%h got %b want %b", c, req_pc, pred, model_pred(req_pc));
      end
      total++;
      if (mcount !== 32'(m_cnt)) begin
        bad++;
        $display("FAIL rand_count: cycle %0d got %0d want %0d", c, mcount, m_cnt);
      end
      end_cycle(1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_mid_init_reset();
    test_back_to_back();
    test_saturation();
    test_alternating();
    test_mispredict();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
